// File: rtl/adder_rr_sched.sv
// adder_rr_sched
//   Round-robin scheduler sharing one unsigned WIDTH-bit adder among N_REQ
//   requesters. One requester is granted per cycle; its operand sum
//   (WIDTH+1 bits, carry in the MSB) and index are registered onto a single
//   response channel with valid/ready backpressure.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : per-requester operand valid
//   req_ready  : per-requester accept, one-hot or zero
//   req_a/b    : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid  : response holds a valid sum
//   rsp_ready  : consumer accepts the response
//   rsp_id     : index of the requester that produced rsp_sum
//   rsp_sum    : registered req_a[g] + req_b[g], WIDTH+1 bits
//   busy       : rsp_valid or any req_valid
module adder_rr_sched #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_REQ = 4,
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH:0]         rsp_sum,
  output logic                   busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [WIDTH:0]   sum_q, sum_d;

  logic [ID_W-1:0]  grant;
  logic             found;
  logic             any_valid;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] a_g, b_g;

  // Priority search starting at ptr_q, wrapping modulo N_REQ. The index is
  // reduced explicitly so non-power-of-two N_REQ never yields an id >= N_REQ.
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] idx_t;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    idx_t = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_t = ID_W'(idx);
      if (!found && req_valid[idx_t]) begin
        found = 1'b1;
        grant = idx_t;
      end
    end
  end

  assign any_valid  = |req_valid;
  assign can_accept = (state_q == EMPTY) || rsp_ready;
  assign accept     = can_accept && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  assign a_g = req_a[grant*WIDTH +: WIDTH];
  assign b_g = req_b[grant*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sum_d   = sum_q;
    if (accept) begin
      // Covers both the EMPTY fill and the FULL drain-and-refill case.
      sum_d   = {1'b0, a_g} + {1'b0, b_g};
      id_d    = grant;
      state_d = FULL;
      ptr_d   = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign busy      = rsp_valid || any_valid;

endmodule

// File: tb/tb_adder_rr_sched.sv
module tb_adder_rr_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [32:0]  rsp_sum;
  logic         busy;

  logic [2:0]   v34;
  logic [2:0]   rdy34;
  logic [101:0] a34, b34;
  logic         rv34, rr34;
  logic [1:0]   id34;
  logic [34:0]  sum34;
  logic         busy34;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_rr_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy)
  );

  adder_rr_sched #(.WIDTH(34), .N_REQ(3)) dut34 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v34), .req_ready(rdy34),
    .req_a(a34), .req_b(b34),
    .rsp_valid(rv34), .rsp_ready(rr34),
    .rsp_id(id34), .rsp_sum(sum34), .busy(busy34)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setop(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    v34 = '0; a34 = '0; b34 = '0; rr34 = 1'b0;
    step(); step();
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_id",    64'(rsp_id),    64'd0);
    chk("rst_sum",   64'(rsp_sum),   64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    rst_n = 1'b1;

    // Single request with carry out
    step();
    setop(2, 32'hFFFF_FFFF, 32'h1);
    req_valid = 4'b0100; rsp_ready = 1'b1;
    #1;
    chk("t1_ready", 64'(req_ready), 64'h4);
    chk("t1_busy",  64'(busy),      64'd1);
    step();
    req_valid = '0;
    chk("t1_valid", 64'(rsp_valid), 64'd1);
    chk("t1_id",    64'(rsp_id),    64'd2);
    chk("t1_sum",   64'(rsp_sum),   64'h1_0000_0000);
    step();
    chk("t1_drain", 64'(rsp_valid), 64'd0);
    chk("t1_hold",  64'(rsp_sum),   64'h1_0000_0000);
    chk("t1_idle",  64'(busy),      64'd0);

    // Async reset pulse between edges restores ptr to 0
    rst_n = 1'b0; #1; rst_n = 1'b1;

    // Full contention
    for (int i = 0; i < 4; i++) setop(i, 32'(i), 32'h10);
    req_valid = 4'hF;
    #1;
    chk("t2_ready0", 64'(req_ready), 64'h1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t2_valid", 64'(rsp_valid), 64'd1);
      chk("t2_id",    64'(rsp_id),    64'(k % 4));
      chk("t2_sum",   64'(rsp_sum),   64'(32'h10 + 32'(k % 4)));
      chk("t2_ready", 64'(req_ready), 64'(4'b0001 << ((k + 1) % 4)));
    end
    req_valid = '0;
    step();
    chk("t2_drain", 64'(rsp_valid), 64'd0);

    // Backpressure (ptr is 2 here)
    setop(1, 32'h2, 32'h3);
    req_valid = 4'b0010;
    step();
    chk("t3_id",  64'(rsp_id),  64'd1);
    chk("t3_sum", 64'(rsp_sum), 64'h5);
    rsp_ready = 1'b0;
    setop(0, 32'h20, 32'h1);
    setop(3, 32'h7, 32'h8);
    req_valid = 4'b1001;
    #1;
    chk("t3_ready_bp", 64'(req_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_bp_valid", 64'(rsp_valid), 64'd1);
      chk("t3_bp_id",    64'(rsp_id),    64'd1);
      chk("t3_bp_sum",   64'(rsp_sum),   64'h5);
      chk("t3_bp_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("t3_rel_ready", 64'(req_ready), 64'h8);
    step();
    chk("t3_rel_valid", 64'(rsp_valid), 64'd1);
    chk("t3_rel_id",    64'(rsp_id),    64'd3);
    chk("t3_rel_sum",   64'(rsp_sum),   64'hF);
    req_valid = 4'b0001;
    #1;
    chk("t3_next_ready", 64'(req_ready), 64'h1);
    step();
    chk("t3_next_id",  64'(rsp_id),  64'd0);
    chk("t3_next_sum", 64'(rsp_sum), 64'h21);
    req_valid = '0;
    step();

    // Pointer hold across idle cycles (ptr is 1 here)
    setop(1, 32'h4, 32'h4);
    req_valid = 4'b0010;
    step();
    chk("t4_id",  64'(rsp_id),  64'd1);
    chk("t4_sum", 64'(rsp_sum), 64'h8);
    req_valid = '0;
    repeat (5) step();
    setop(2, 32'h100, 32'h23);
    req_valid = 4'b0101;
    #1;
    chk("t4_ready_a", 64'(req_ready), 64'h4);
    step();
    chk("t4_id_a",  64'(rsp_id),  64'd2);
    chk("t4_sum_a", 64'(rsp_sum), 64'h123);
    chk("t4_ready_b", 64'(req_ready), 64'h1);
    step();
    chk("t4_id_b",  64'(rsp_id),  64'd0);
    chk("t4_sum_b", 64'(rsp_sum), 64'h21);
    req_valid = '0;
    step();

    // Reset mid-operation
    setop(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'b1000;
    step();
    chk("t5_full_sum", 64'(rsp_sum),   64'h1_FFFF_FFFE);
    chk("t5_full_vld", 64'(rsp_valid), 64'd1);
    req_valid = '0; rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 64'(rsp_valid), 64'd0);
    chk("t5_async_sum",   64'(rsp_sum),   64'd0);
    chk("t5_async_id",    64'(rsp_id),    64'd0);
    rst_n = 1'b1;
    setop(1, 32'h1, 32'h2);
    req_valid = 4'b1010; rsp_ready = 1'b1;
    #1;
    chk("t5_ready", 64'(req_ready), 64'h2);
    step();
    chk("t5_id",  64'(rsp_id),  64'd1);
    chk("t5_sum", 64'(rsp_sum), 64'h3);
    req_valid = '0;
    step();

    // WIDTH=34, N_REQ=3: max operands and pointer wrap from 2 to 0
    a34[68 +: 34] = 34'h3_FFFF_FFFF;
    b34[68 +: 34] = 34'h3_FFFF_FFFF;
    v34 = 3'b100; rr34 = 1'b1;
    #1;
    chk("w34_ready", 64'(rdy34), 64'h4);
    step();
    chk("w34_sum", 64'(sum34), 64'h7_FFFF_FFFE);
    chk("w34_id",  64'(id34),  64'd2);
    a34[0 +: 34] = 34'h1;  b34[0 +: 34] = 34'h1;
    a34[34 +: 34] = 34'h5; b34[34 +: 34] = 34'h5;
    v34 = 3'b011;
    #1;
    chk("w34_wrap_ready", 64'(rdy34), 64'h1);
    step();
    chk("w34_wrap_id",  64'(id34),  64'd0);
    chk("w34_wrap_sum", 64'(sum34), 64'h2);
    chk("w34_next_ready", 64'(rdy34), 64'h2);
    v34 = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
